// File: rtl/instr_queue.sv
// In-order instruction buffer between fetch and dispatch: a circular FIFO of {pc, instr}
// feeding an output register, with ROB stall back-pressure and exception flush/redirect.
module instr_queue #(
  parameter int QueueSize     = 16,
  parameter int PointerLength = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_valid_from_fetch,
  input  logic [31:0] instr_from_fetch,
  input  logic [31:0] pc_from_fetch,
  input  logic        is_stall_from_rob,
  input  logic        is_exception_from_rob,
  input  logic [31:0] pc_from_rob,
  output logic        is_stall_to_fetch,
  output logic        is_exception_to_fetch,
  output logic [31:0] pc_to_fetch,
  output logic        is_valid_to_reg,
  output logic [31:0] instr_to_reg,
  output logic [31:0] pc_to_reg
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [PointerLength:0] FullCount = (PointerLength + 1)'(QueueSize);

  state_t                   state, state_next;
  logic [31:0]              mem_instr [QueueSize];
  logic [31:0]              mem_pc    [QueueSize];
  logic [PointerLength-1:0] head, tail;
  logic [PointerLength:0]   count;
  logic                     push, consume, load;

  // A push is blocked while full even if the output register drains this same cycle.
  assign push    = is_valid_from_fetch & ~is_stall_to_fetch & ~is_exception_from_rob;
  assign consume = is_valid_to_reg & ~is_stall_from_rob;
  assign load    = (~is_valid_to_reg | consume) & (count != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_next;
  end

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_next = RUN;
    case (state)
      RUN:     if (is_exception_from_rob) state_next = FLUSH;
      FLUSH:   if (is_exception_from_rob) state_next = FLUSH;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    is_stall_to_fetch = 1'b0;
    if (count == FullCount || state == FLUSH) is_stall_to_fetch = 1'b1;
  end

  // NOTE: the storage array is deliberately not reset; validity is tracked by head/tail/count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[tail] <= instr_from_fetch;
      mem_pc[tail]    <= pc_from_fetch;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head                  <= '0;
      tail                  <= '0;
      count                 <= '0;
      is_valid_to_reg       <= 1'b0;
      instr_to_reg          <= '0;
      pc_to_reg             <= '0;
      is_exception_to_fetch <= 1'b0;
      pc_to_fetch           <= '0;
    end else if (is_exception_from_rob) begin
      head                  <= '0;
      tail                  <= '0;
      count                 <= '0;
      is_valid_to_reg       <= 1'b0;
      is_exception_to_fetch <= 1'b1;
      pc_to_fetch           <= pc_from_rob;
    end else begin
      is_exception_to_fetch <= 1'b0;
      if (push) tail <= tail + 1'b1;
      if (load) begin
        is_valid_to_reg <= 1'b1;
        instr_to_reg    <= mem_instr[head];
        pc_to_reg       <= mem_pc[head];
        head            <= head + 1'b1;
      end else if (consume) begin
        is_valid_to_reg <= 1'b0;
      end
      case ({push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: cycle vector table plus fill/drain, wrap and reset
// sequences, with a scoreboard checking dispatch order against what fetch handed over.
module tb_instr_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        is_valid_from_fetch = 1'b0;
  logic [31:0] instr_from_fetch = '0;
  logic [31:0] pc_from_fetch = '0;
  logic        is_stall_from_rob = 1'b0;
  logic        is_exception_from_rob = 1'b0;
  logic [31:0] pc_from_rob = '0;
  logic        is_stall_to_fetch;
  logic        is_exception_to_fetch;
  logic [31:0] pc_to_fetch;
  logic        is_valid_to_reg;
  logic [31:0] instr_to_reg;
  logic [31:0] pc_to_reg;

  instr_queue #(.QueueSize(16), .PointerLength(4)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .is_valid_from_fetch   (is_valid_from_fetch),
    .instr_from_fetch      (instr_from_fetch),
    .pc_from_fetch         (pc_from_fetch),
    .is_stall_from_rob     (is_stall_from_rob),
    .is_exception_from_rob (is_exception_from_rob),
    .pc_from_rob           (pc_from_rob),
    .is_stall_to_fetch     (is_stall_to_fetch),
    .is_exception_to_fetch (is_exception_to_fetch),
    .pc_to_fetch           (pc_to_fetch),
    .is_valid_to_reg       (is_valid_to_reg),
    .instr_to_reg          (instr_to_reg),
    .pc_to_reg             (pc_to_reg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        st;
    logic        ex;
    logic [31:0] rpc;
    logic        e_vr;
    logic [31:0] e_pcr;
    logic        e_sf;
    logic        e_ef;
    logic [31:0] e_pcf;
  } vec_t;

  entry_t sb[$];
  entry_t mon_e;
  int     n_checks = 0;
  int     n_fail   = 0;

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return {~pc[15:0], pc[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic st,
                       input logic ex, input logic [31:0] rpc);
    is_valid_from_fetch   = v;
    pc_from_fetch         = pc;
    instr_from_fetch      = mk_instr(pc);
    is_stall_from_rob     = st;
    is_exception_from_rob = ex;
    pc_from_rob           = rpc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Inputs are stable at the falling edge, so this sees exactly what the next rising edge acts on.
  always @(negedge clk) begin
    if (rst) begin
      if (is_exception_from_rob) begin
        sb.delete();
      end else begin
        if (is_valid_to_reg && !is_stall_from_rob) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL dispatch_unexpected: pc %h dispatched with none pending", pc_to_reg);
          end else begin
            mon_e = sb.pop_front();
            check("dispatch_pc", pc_to_reg, mon_e.pc);
            check("dispatch_instr", instr_to_reg, mon_e.instr);
          end
        end
        if (is_valid_from_fetch && !is_stall_to_fetch)
          sb.push_back('{pc_from_fetch, mk_instr(pc_from_fetch)});
      end
    end
  end

  initial begin
    vec_t vecs[20];
    logic acc;
    int   n;

    vecs[0]  = '{1'b1, 32'h00,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h04,  1'b0, 1'b0, 32'h0,   1'b1, 32'h0,  1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 32'h08,  1'b0, 1'b0, 32'h0,   1'b1, 32'h4,  1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h00,  1'b0, 1'b0, 32'h0,   1'b1, 32'h8,  1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h00,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 32'h10,  1'b1, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 32'h14,  1'b1, 1'b0, 32'h0,   1'b1, 32'h10, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 32'h18,  1'b1, 1'b0, 32'h0,   1'b1, 32'h10, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 32'h1c,  1'b1, 1'b0, 32'h0,   1'b1, 32'h10, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 32'h20,  1'b1, 1'b0, 32'h0,   1'b1, 32'h10, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 32'h24,  1'b1, 1'b0, 32'h0,   1'b1, 32'h10, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 32'h28,  1'b1, 1'b1, 32'h100, 1'b0, 32'h0,  1'b1, 1'b1, 32'h100};
    vecs[12] = '{1'b1, 32'h2c,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 1'b0, 32'h100};
    vecs[13] = '{1'b0, 32'h00,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 1'b0, 32'h100};
    vecs[14] = '{1'b0, 32'h00,  1'b0, 1'b1, 32'h100, 1'b0, 32'h0,  1'b1, 1'b1, 32'h100};
    vecs[15] = '{1'b0, 32'h00,  1'b0, 1'b1, 32'h200, 1'b0, 32'h0,  1'b1, 1'b1, 32'h200};
    vecs[16] = '{1'b0, 32'h00,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 1'b0, 32'h200};
    vecs[17] = '{1'b1, 32'h30,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 1'b0, 32'h200};
    vecs[18] = '{1'b0, 32'h00,  1'b0, 1'b0, 32'h0,   1'b1, 32'h30, 1'b0, 1'b0, 32'h200};
    vecs[19] = '{1'b0, 32'h00,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 1'b0, 32'h200};

    #2;
    check("reset_valid", is_valid_to_reg, 0);
    check("reset_instr", instr_to_reg, 0);
    check("reset_pc", pc_to_reg, 0);
    check("reset_stall", is_stall_to_fetch, 0);
    check("reset_exc", is_exception_to_fetch, 0);
    check("reset_pc_fetch", pc_to_fetch, 0);

    @(negedge clk);
    rst = 1'b1;

    // Basic flow, flush with a same-cycle fetch, back-to-back exceptions, recovery.
    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].pc, vecs[i].st, vecs[i].ex, vecs[i].rpc);
      step();
      check($sformatf("row%0d_valid", i), is_valid_to_reg, vecs[i].e_vr);
      check($sformatf("row%0d_stall", i), is_stall_to_fetch, vecs[i].e_sf);
      check($sformatf("row%0d_exc", i), is_exception_to_fetch, vecs[i].e_ef);
      check($sformatf("row%0d_pc_fetch", i), pc_to_fetch, vecs[i].e_pcf);
      if (vecs[i].e_vr) begin
        check($sformatf("row%0d_pc_reg", i), pc_to_reg, vecs[i].e_pcr);
        check($sformatf("row%0d_instr_reg", i), instr_to_reg, mk_instr(vecs[i].e_pcr));
      end
    end

    // Fill under ROB stall: one in the output register plus 16 in the FIFO.
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 32'h1000 + 32'(4 * i), 1'b1, 1'b0, 32'h0);
      step();
      check($sformatf("fill%0d_stall", i), is_stall_to_fetch, 32'(i == 16));
    end
    drive(1'b1, 32'h1044, 1'b1, 1'b0, 32'h0);
    step();
    check("full_refuse_stall", is_stall_to_fetch, 1);
    check("full_hold_pc", pc_to_reg, 32'h1000);

    // Single pop while full: push still refused that cycle, accepted on the next.
    drive(1'b1, 32'h1044, 1'b0, 1'b0, 32'h0);
    step();
    check("one_pop_stall", is_stall_to_fetch, 0);
    check("one_pop_valid", is_valid_to_reg, 1);
    check("one_pop_pc", pc_to_reg, 32'h1004);
    drive(1'b1, 32'h1044, 1'b1, 1'b0, 32'h0);
    step();
    check("refill_stall", is_stall_to_fetch, 1);

    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 17; i++) begin
      step();
      check($sformatf("drain%0d_valid", i), is_valid_to_reg, 32'(i < 16));
    end
    check("drain_empty", sb.size(), 0);

    // Random ROB stalls across more than two pointer wraps; fetch holds until accepted.
    n = 0;
    for (int cyc = 0; cyc < 2000 && n < 40; cyc++) begin
      drive(1'b1, 32'h2000 + 32'(4 * n), $urandom_range(0, 9) < 4, 1'b0, 32'h0);
      @(negedge clk);
      acc = !is_stall_to_fetch;
      step();
      if (acc) n++;
    end
    check("wrap_pushes", n, 40);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int cyc = 0; cyc < 100 && sb.size() > 0; cyc++) step();
    check("wrap_drain", sb.size(), 0);
    step();
    check("wrap_idle_valid", is_valid_to_reg, 0);

    // Asynchronous reset in the middle of a cycle with live state.
    drive(1'b1, 32'h3000, 1'b1, 1'b0, 32'h0);
    step();
    step();
    check("pre_reset_valid", is_valid_to_reg, 1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    sb.delete();
    #1;
    check("async_reset_valid", is_valid_to_reg, 0);
    check("async_reset_instr", instr_to_reg, 0);
    check("async_reset_pc", pc_to_reg, 0);
    check("async_reset_stall", is_stall_to_fetch, 0);
    check("async_reset_exc", is_exception_to_fetch, 0);
    check("async_reset_pc_fetch", pc_to_fetch, 0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 32'h4000, 1'b0, 1'b0, 32'h0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    check("post_reset_valid", is_valid_to_reg, 1);
    check("post_reset_pc", pc_to_reg, 32'h4000);
    step();
    check("post_reset_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
